// File: rtl/rs_syndrome_16_8.sv
// RS(16,8) syndrome stage: Horner-accumulates S0..S7 over GF(256) and strobes them one clock after the 16th symbol.
// Optional framing checks (eop placement, sop inside a frame) are enabled by defining RS_SYND_FRMCHK_EN.
module rs_syndrome_16_8 #(
  parameter int unsigned FCR     = 0,
  parameter logic [8:0]  GF_POLY = 9'h11D,
  parameter int unsigned N_SYM   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din_val,
  input  logic        din_sop,
  input  logic        din_eop,
  input  logic [7:0]  din,
  output logic        synd_val,
  output logic [63:0] synd,
  output logic        synd_nz,
  output logic        frm_err
);

  localparam int unsigned SW = 8;
  localparam int unsigned NR = 8;
  localparam int unsigned CW = 4;

  // Shift-and-add GF(2^8) product; constant b folds to an XOR network.
  function automatic logic [SW-1:0] gf_mul(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic [SW-1:0] p;
    logic [SW-1:0] x;
    p = '0;
    x = a;
    for (int k = 0; k < int'(SW); k++) begin
      if (b[k]) p = p ^ x;
      x = x[SW-1] ? ((x << 1) ^ GF_POLY[SW-1:0]) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [SW-1:0] gf_pow(input int unsigned e);
    logic [SW-1:0] r;
    r = SW'(1);
    for (int unsigned k = 0; k < e; k++) r = gf_mul(r, SW'(2));
    return r;
  endfunction

  logic [NR-1:0][SW-1:0] r_acc;
  logic [NR-1:0][SW-1:0] w_acc_nxt;
  logic [CW-1:0]         r_cnt;
  logic                  r_in_frame;
  logic [NR*SW-1:0]      r_synd;
  logic                  r_synd_val;
  logic                  r_synd_nz;
  logic                  r_frm_err;

  logic w_take_sop;
  logic w_take_dat;
  logic w_last;
  logic w_done;
  logic w_err;
  logic w_sop_keep;

  assign w_take_sop = din_val & din_sop;
  assign w_take_dat = din_val & ~din_sop & r_in_frame;
  assign w_last     = w_take_dat & (r_cnt == CW'(N_SYM - 1));

`ifdef RS_SYND_FRMCHK_EN
  // A sop carrying eop is a one-symbol frame, so it is dropped rather than restarted.
  assign w_err      = (w_take_sop & (r_in_frame | din_eop)) |
                      (w_take_dat & (w_last ? ~din_eop : din_eop));
  assign w_done     = w_last & din_eop;
  assign w_sop_keep = ~din_eop;
`else
  logic w_unused_eop;
  assign w_unused_eop = din_eop;
  assign w_err        = 1'b0;
  assign w_done       = w_last;
  assign w_sop_keep   = 1'b1;
`endif

  for (genvar gi = 0; gi < NR; gi++) begin : g_lane
    localparam logic [SW-1:0] ROOT = gf_pow(FCR + gi);
    assign w_acc_nxt[gi] = din_sop ? din : (gf_mul(r_acc[gi], ROOT) ^ din);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_in_frame <= 1'b0;
      r_synd     <= '0;
      r_synd_val <= 1'b0;
      r_synd_nz  <= 1'b0;
      r_frm_err  <= 1'b0;
    end else begin
      r_synd_val <= w_done;
      r_frm_err  <= w_err;
      if (w_take_sop | w_take_dat) begin
        r_acc <= w_acc_nxt;
        r_cnt <= w_take_sop ? CW'(1) : (r_cnt + CW'(1));
      end
      if (w_take_sop) begin
        r_in_frame <= w_sop_keep;
      end else if (w_last | w_err) begin
        r_in_frame <= 1'b0;
      end
      if (w_done) begin
        r_synd    <= w_acc_nxt;
        r_synd_nz <= |w_acc_nxt;
      end
    end
  end

  assign synd_val = r_synd_val;
  assign synd     = r_synd;
  assign synd_nz  = r_synd_nz;
  assign frm_err  = r_frm_err;

endmodule
